csr_counter_unit: RTL and testbench

Execute-stage CSR responder that owns the 64-bit cycle and instret counters.
- Serves CSR instructions decoded by ID and carried into EXE through the ID/EXE pipeline register: csrrw/csrrs/csrrc and their immediate forms.
- Returns registered read data to the EXE/MEM register.
- Replaces the ad-hoc counter logic in pipeline registers; the retire pulse comes from the WB stage.

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_counter64.sv | 53 +++++
 rtl/csr_counter_unit.sv | 167 ++++++++++++++++
 tb/tb_csr_counter_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the execute-stage CSR counter unit.
//   - CSR address constants for the counter CSRs and mcountinhibit
//   - csr_op_e: funct3 encodings of the CSR instructions
//   - mcountinhibit bit indices and the decoded-target enum used by the top
package csr_pkg;

    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    localparam int unsigned INH_CY = 0;
    localparam int unsigned INH_IR = 2;
    localparam logic [31:0] INH_MASK = 32'h0000_0005;

    // Which physical word an address resolves to.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CYC_LO,
        SEL_CYC_HI,
        SEL_INS_LO,
        SEL_INS_HI,
        SEL_INH
    } csr_sel_e;

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free-running counter built from two 32-bit halves,
// each half writable independently.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (loads RST_VAL)
//   inc_i    increment by one this cycle
//   wr_lo_i  write low word with wdata_i
//   wr_hi_i  write high word with wdata_i
//   wdata_i  32-bit write data
//   value_o  current 64-bit value
module csr_counter64 #(
    parameter logic [63:0] RST_VAL = 64'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        carry;

    always_comb begin
        {carry, lo_d} = {1'b0, lo_q} + {32'd0, inc_i};
        hi_d          = hi_q + {31'd0, carry};
        // Low write wins over the increment and suppresses the carry.
        if (wr_lo_i) begin
            lo_d = wdata_i;
            hi_d = hi_q;
        end
        // High write replaces high; low still counts but its carry is dropped.
        if (wr_hi_i) begin
            hi_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lo_q <= RST_VAL[31:0];
            hi_q <= RST_VAL[63:32];
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_counter_unit.sv
// csr_counter_unit: execute-stage CSR responder owning the 64-bit cycle and
// instret counters. Serves csrrw/csrrs/csrrc (and immediate forms) with
// read-before-write semantics and registered read data.
// Ports:
//   clk, reset (async active-low)
//   im_stall, dm_stall        memory stalls; block CSR operation
//   csr_valid, csr_flush      EXE holds a CSR op / op is killed
//   csr_funct3, csr_addr      op encoding and CSR address
//   csr_src, csr_src_zero     operand and its "rs1/zimm is zero" flag
//   retire                    one instruction retired in WB
//   csr_rdata                 registered old CSR value
//   csr_illegal               registered one-cycle illegal-access pulse
//   cycle_out, instret_out    live counter values
// Build option: define CSR_INHIBIT_EN to add mcountinhibit at 0x320.
module csr_counter_unit
    import csr_pkg::*;
#(
    parameter logic [63:0] CYCLE_RST   = 64'd0,
    parameter logic [63:0] INSTRET_RST = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        im_stall,
    input  logic        dm_stall,
    input  logic        csr_valid,
    input  logic        csr_flush,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_src,
    input  logic        csr_src_zero,
    input  logic        retire,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [63:0] cycle_out,
    output logic [63:0] instret_out
);

    logic        fire;
    csr_sel_e    sel;
    logic        read_only;
    logic        op_ok, is_rw, is_rs;
    logic        wr_req, do_wr;
    logic [31:0] old_val, wval;
    logic [31:0] rdata_q, rdata_d;
    logic        illegal_q, illegal_d;
    logic [31:0] inh_val;
    logic        cy_inc, ir_inc;
    logic [63:0] cycle_val, instret_val;

    assign fire = csr_valid & ~csr_flush & ~im_stall & ~dm_stall;

    // Address decode
    always_comb begin
        sel       = SEL_NONE;
        read_only = 1'b0;
        case (csr_addr)
            CSR_CYCLE:     begin sel = SEL_CYC_LO; read_only = 1'b1; end
            CSR_CYCLEH:    begin sel = SEL_CYC_HI; read_only = 1'b1; end
            CSR_INSTRET:   begin sel = SEL_INS_LO; read_only = 1'b1; end
            CSR_INSTRETH:  begin sel = SEL_INS_HI; read_only = 1'b1; end
            CSR_MCYCLE:    sel = SEL_CYC_LO;
            CSR_MCYCLEH:   sel = SEL_CYC_HI;
            CSR_MINSTRET:  sel = SEL_INS_LO;
            CSR_MINSTRETH: sel = SEL_INS_HI;
`ifdef CSR_INHIBIT_EN
            CSR_MCOUNTINHIBIT: sel = SEL_INH;
`endif
            default: ;
        endcase
    end

    // Old-value mux
    always_comb begin
        old_val = '0;
        case (sel)
            SEL_CYC_LO: old_val = cycle_val[31:0];
            SEL_CYC_HI: old_val = cycle_val[63:32];
            SEL_INS_LO: old_val = instret_val[31:0];
            SEL_INS_HI: old_val = instret_val[63:32];
            SEL_INH:    old_val = inh_val;
            default:    old_val = '0;
        endcase
    end

    // Op decode; funct3 000/100 leave op_ok low and act as no-ops.
    always_comb begin
        op_ok = 1'b1;
        is_rw = 1'b0;
        is_rs = 1'b0;
        case (csr_op_e'(csr_funct3))
            CSR_RW, CSR_RWI: is_rw = 1'b1;
            CSR_RS, CSR_RSI: is_rs = 1'b1;
            CSR_RC, CSR_RCI: ;
            default:         op_ok = 1'b0;
        endcase
    end

    assign wval = is_rw ? csr_src :
                  is_rs ? (old_val | csr_src) : (old_val & ~csr_src);

    // Set/clear with a zero operand is a pure read, even on read-only CSRs.
    assign wr_req = is_rw | ~csr_src_zero;
    assign do_wr  = fire & op_ok & (sel != SEL_NONE) & ~read_only & wr_req;

    assign illegal_d = fire & op_ok & ((sel == SEL_NONE) | (read_only & wr_req));
    assign rdata_d   = (fire & op_ok) ? old_val : rdata_q;

`ifdef CSR_INHIBIT_EN
    logic [31:0] inh_q, inh_d;

    // Inhibit bits are registered, so a write affects the next cycle's increment.
    assign inh_d = (do_wr && sel == SEL_INH) ? (wval & INH_MASK) : inh_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) inh_q <= '0;
        else        inh_q <= inh_d;
    end

    assign inh_val = inh_q;
    assign cy_inc  = ~inh_q[INH_CY];
    assign ir_inc  = retire & ~inh_q[INH_IR];
`else
    assign inh_val = '0;
    assign cy_inc  = 1'b1;
    assign ir_inc  = retire;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

    csr_counter64 #(
        .RST_VAL (CYCLE_RST)
    ) u_cycle (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (cy_inc),
        .wr_lo_i (do_wr && sel == SEL_CYC_LO),
        .wr_hi_i (do_wr && sel == SEL_CYC_HI),
        .wdata_i (wval),
        .value_o (cycle_val)
    );

    csr_counter64 #(
        .RST_VAL (INSTRET_RST)
    ) u_instret (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (ir_inc),
        .wr_lo_i (do_wr && sel == SEL_INS_LO),
        .wr_hi_i (do_wr && sel == SEL_INS_HI),
        .wdata_i (wval),
        .value_o (instret_val)
    );

    assign csr_rdata   = rdata_q;
    assign csr_illegal = illegal_q;
    assign cycle_out   = cycle_val;
    assign instret_out = instret_val;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Testbench for csr_counter_unit: table of CSR operations with a reference
// model of both counters; expected read data / illegal pulse are queued when
// an operation is driven and compared after the clock edge.
// Define CSR_INHIBIT_EN to also exercise mcountinhibit.
module tb_csr_counter_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        im_stall, dm_stall, csr_valid, csr_flush;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_src;
    logic        csr_src_zero, retire;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [63:0] cycle_out, instret_out;

    csr_counter_unit #(
        .CYCLE_RST   (64'd0),
        .INSTRET_RST (64'd0)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .im_stall     (im_stall),
        .dm_stall     (dm_stall),
        .csr_valid    (csr_valid),
        .csr_flush    (csr_flush),
        .csr_funct3   (csr_funct3),
        .csr_addr     (csr_addr),
        .csr_src      (csr_src),
        .csr_src_zero (csr_src_zero),
        .retire       (retire),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .cycle_out    (cycle_out),
        .instret_out  (instret_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, flush, ims, dms;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] src;
        logic        sz, ret;
        int unsigned rep;
        logic        exp_ill;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_cyc, m_ins;
    logic [31:0] m_rd, m_inh;
    int unsigned n_tot = 0, n_pass = 0;
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic valid, input logic flush, input logic ims,
                                input logic dms, input logic [2:0] f3, input logic [11:0] addr,
                                input logic [31:0] src, input logic sz, input logic ret,
                                input int unsigned rep, input logic exp_ill,
                                input logic chk_rd, input logic [31:0] exp_rd);
        vec_t v;
        v.valid = valid; v.flush = flush; v.ims = ims; v.dms = dms;
        v.f3 = f3; v.addr = addr; v.src = src; v.sz = sz; v.ret = ret;
        v.rep = rep; v.exp_ill = exp_ill; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        return v;
    endfunction

    function automatic vec_t idle(input logic ret, input int unsigned rep);
        return mk(0, 0, 0, 0, 3'b000, 12'h000, 32'h0, 1, ret, rep, 0, 0, 32'h0);
    endfunction

    function automatic vec_t op(input logic [2:0] f3, input logic [11:0] addr,
                                input logic [31:0] src, input logic sz, input logic ret,
                                input logic exp_ill, input logic chk_rd, input logic [31:0] exp_rd);
        return mk(1, 0, 0, 0, f3, addr, src, sz, ret, 1, exp_ill, chk_rd, exp_rd);
    endfunction

    // One clock: drive, predict, clock, compare.
    task automatic step(input vec_t v);
        logic        fire, ok, mapped, ro, wrq, wr;
        logic [1:0]  kind;
        logic [31:0] old, wv, ninh;
        logic [63:0] nc, ni;
        exp_t        e, got;
        csr_valid = v.valid; csr_flush = v.flush; im_stall = v.ims; dm_stall = v.dms;
        csr_funct3 = v.f3; csr_addr = v.addr; csr_src = v.src;
        csr_src_zero = v.sz; retire = v.ret;

        fire   = v.valid && !v.flush && !v.ims && !v.dms;
        kind   = v.f3[1:0];
        ok     = (kind != 2'b00);
        mapped = 1'b1;
        old    = 32'h0;
        case (v.addr)
            12'hC00, 12'hB00: old = m_cyc[31:0];
            12'hC80, 12'hB80: old = m_cyc[63:32];
            12'hC02, 12'hB02: old = m_ins[31:0];
            12'hC82, 12'hB82: old = m_ins[63:32];
`ifdef CSR_INHIBIT_EN
            12'h320:          old = m_inh;
`endif
            default:          mapped = 1'b0;
        endcase
        ro  = mapped && (v.addr[11:8] == 4'hC);
        wrq = (kind == 2'b01) || !v.sz;
        wv  = (kind == 2'b01) ? v.src : (kind == 2'b10) ? (old | v.src) : (old & ~v.src);
        wr  = fire && ok && mapped && !ro && wrq;

        nc   = m_cyc + (m_inh[0] ? 64'd0 : 64'd1);
        ni   = m_ins + ((v.ret && !m_inh[2]) ? 64'd1 : 64'd0);
        ninh = m_inh;
        if (wr) begin
            case (v.addr)
                12'hB00: nc = {m_cyc[63:32], wv};
                12'hB80: nc = {wv, m_cyc[31:0] + (m_inh[0] ? 32'd0 : 32'd1)};
                12'hB02: ni = {m_ins[63:32], wv};
                12'hB82: ni = {wv, m_ins[31:0] + ((v.ret && !m_inh[2]) ? 32'd1 : 32'd0)};
                12'h320: ninh = wv & 32'h5;
                default: ;
            endcase
        end
        if (fire && ok) m_rd = mapped ? old : 32'h0;
        m_cyc = nc; m_ins = ni; m_inh = ninh;
        e.rd  = m_rd;
        e.ill = v.exp_ill;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            got = exp_q.pop_front();
            chk($sformatf("rdata@%03h", v.addr), {32'd0, csr_rdata}, {32'd0, got.rd});
            chk($sformatf("illegal@%03h", v.addr), {63'd0, csr_illegal}, {63'd0, got.ill});
        end
        chk("cycle", cycle_out, m_cyc);
        chk("instret", instret_out, m_ins);
        if (v.chk_rd) chk($sformatf("rdata_const@%03h", v.addr), {32'd0, csr_rdata}, {32'd0, v.exp_rd});
    endtask

    task automatic model_reset();
        m_cyc = 64'd0; m_ins = 64'd0; m_rd = 32'h0; m_inh = 32'h0;
    endtask

    logic [63:0] frz_c, frz_i;

    initial begin
        rst_n = 1'b0;
        im_stall = 0; dm_stall = 0; csr_valid = 0; csr_flush = 0;
        csr_funct3 = 3'b000; csr_addr = '0; csr_src = '0; csr_src_zero = 1; retire = 0;
        model_reset();

        // Table: {valid,flush,ims,dms,f3,addr,src,sz,ret,rep,exp_ill,chk_rd,exp_rd}
        tbl.push_back(idle(0, 10));
        tbl.push_back(op(3'b010, 12'hC00, 32'h0, 1, 0, 0, 1, 32'd10));
        tbl.push_back(idle(1, 5));
        tbl.push_back(op(3'b010, 12'hC02, 32'h0, 1, 0, 0, 1, 32'd5));
        tbl.push_back(op(3'b010, 12'hC82, 32'h0, 1, 0, 0, 1, 32'd0));
        tbl.push_back(op(3'b001, 12'hB00, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0));
        tbl.push_back(idle(0, 1));
        tbl.push_back(op(3'b010, 12'hB80, 32'h0, 1, 0, 0, 1, 32'd1));
        tbl.push_back(op(3'b001, 12'hC00, 32'h1234, 0, 0, 1, 0, 32'h0));
        tbl.push_back(op(3'b010, 12'hC00, 32'h0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 1, 3'b001, 12'hB02, 32'h0, 0, 0, 3, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 0, 3'b001, 12'hB02, 32'h0, 0, 0, 2, 0, 0, 32'h0));
        tbl.push_back(op(3'b011, 12'hB02, 32'h1, 0, 0, 0, 1, 32'd5));
        tbl.push_back(op(3'b010, 12'hB02, 32'h0, 1, 0, 0, 1, 32'd4));
        tbl.push_back(mk(1, 1, 0, 0, 3'b001, 12'hB02, 32'h0, 1, 0, 1, 0, 0, 32'h0));
        tbl.push_back(op(3'b010, 12'hB02, 32'h0, 1, 0, 0, 1, 32'd4));
        tbl.push_back(op(3'b010, 12'h123, 32'h0, 1, 0, 1, 1, 32'd0));
`ifdef CSR_INHIBIT_EN
        tbl.push_back(op(3'b010, 12'h320, 32'h0, 1, 0, 0, 1, 32'd0));
`else
        tbl.push_back(op(3'b010, 12'h320, 32'h0, 1, 0, 1, 1, 32'd0));
`endif
        tbl.push_back(op(3'b011, 12'hC80, 32'h1, 0, 0, 1, 0, 32'h0));
        tbl.push_back(op(3'b000, 12'hB00, 32'h5, 0, 0, 0, 0, 32'h0));
        tbl.push_back(op(3'b100, 12'h123, 32'h5, 0, 0, 0, 0, 32'h0));
        tbl.push_back(op(3'b001, 12'hB00, 32'h100, 0, 0, 0, 0, 32'h0));
        tbl.push_back(op(3'b010, 12'hB00, 32'h0, 1, 0, 0, 1, 32'h100));
        tbl.push_back(op(3'b001, 12'hB02, 32'hFFFF_FFFF, 0, 1, 0, 0, 32'h0));
        tbl.push_back(op(3'b001, 12'hB82, 32'h7, 0, 1, 0, 0, 32'h0));
        tbl.push_back(op(3'b010, 12'hB82, 32'h0, 1, 0, 0, 1, 32'd7));
        tbl.push_back(op(3'b010, 12'hB02, 32'h0, 1, 0, 0, 1, 32'd0));
        tbl.push_back(op(3'b110, 12'hB00, 32'h1_0000, 0, 0, 0, 0, 32'h0));
        tbl.push_back(op(3'b111, 12'hB80, 32'h1, 0, 0, 0, 1, 32'd1));
        tbl.push_back(op(3'b010, 12'hB80, 32'h0, 1, 0, 0, 1, 32'd0));
        tbl.push_back(op(3'b101, 12'hB80, 32'h3, 0, 0, 0, 0, 32'h0));
        tbl.push_back(op(3'b001, 12'hB80, 32'h0, 1, 0, 0, 1, 32'd3));
        tbl.push_back(op(3'b010, 12'hB80, 32'h0, 1, 0, 0, 1, 32'd0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cycle", cycle_out, 64'd0);
        chk("reset_instret", instret_out, 64'd0);
        chk("reset_rdata", {32'd0, csr_rdata}, 64'd0);
        chk("reset_illegal", {63'd0, csr_illegal}, 64'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            for (int unsigned r = 0; r < tbl[i].rep; r++) step(tbl[i]);
        end

        // Reset asserted with a write pending: everything returns to reset values.
        csr_valid = 1; csr_funct3 = 3'b001; csr_addr = 12'hB00; csr_src = 32'hDEAD; csr_src_zero = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_cycle", cycle_out, 64'd0);
        chk("midreset_instret", instret_out, 64'd0);
        chk("midreset_rdata", {32'd0, csr_rdata}, 64'd0);
        chk("midreset_illegal", {63'd0, csr_illegal}, 64'd0);
        @(posedge clk);
        #1;
        chk("held_in_reset_cycle", cycle_out, 64'd0);
        model_reset();
        rst_n = 1'b1;
        step(idle(0, 1));
        step(op(3'b010, 12'hB00, 32'h0, 1, 0, 0, 1, 32'd1));

`ifdef CSR_INHIBIT_EN
        // Freeze both counters, then confirm neither moves over 20 cycles.
        step(op(3'b001, 12'h320, 32'h5, 0, 0, 0, 0, 32'h0));
        frz_c = m_cyc;
        frz_i = m_ins;
        for (int unsigned k = 0; k < 20; k++) step(idle(1, 1));
        chk("inhibit_cycle_frozen", cycle_out, frz_c);
        chk("inhibit_instret_frozen", instret_out, frz_i);
        step(op(3'b010, 12'h320, 32'h0, 1, 0, 0, 1, 32'h5));
        step(op(3'b011, 12'h320, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'h5));
        step(idle(1, 1));
        step(idle(1, 1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
